// File: rtl/audio_bypass_xfade.sv
// Wet/dry selector with a click-free linear crossfade over 2^RAMP_LOG2 samples.
// Define AUDIO_XFADE_EN for the gain ramp; otherwise a hard switch at the sample boundary.
module audio_bypass_xfade #(
    parameter int W         = 24,
    parameter int CH        = 2,
    parameter int RAMP_LOG2 = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            sample_trig,
    input  logic [CH*W-1:0] dry_in,
    input  logic [CH*W-1:0] wet_in,
    output logic [CH*W-1:0] data_out,
    output logic            valid_out,
    output logic            busy,
    output logic            wet_active
);

    localparam int GW = RAMP_LOG2 + 1;
    localparam logic [GW-1:0] G_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_DRY,
        ST_RAMP_UP,
        ST_WET,
        ST_RAMP_DOWN
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     g_q, g_d;
    logic [CH*W-1:0]   data_q, data_d;
    logic              valid_q, valid_d;
    logic [CH*W-1:0]   blend;

    // Gain update: one step per strobe towards the requested end point.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        g_d = g_q;
        if (sample_trig) begin
`ifdef AUDIO_XFADE_EN
            if (enable && (g_q != G_MAX)) begin
                g_d = g_q + GW'(1);
            end else if (!enable && (g_q != '0)) begin
                g_d = g_q - GW'(1);
            end
`else
            g_d = enable ? G_MAX : '0;
`endif
        end
    end

    // Next state follows the new gain; direction comes from the sampled enable.
    always_comb begin
        state_d = state_q;
        if (sample_trig) begin
            if (g_d == G_MAX) begin
                state_d = ST_WET;
            end else if (g_d == '0) begin
                state_d = ST_DRY;
            end else if (enable) begin
                state_d = ST_RAMP_UP;
            end else begin
                state_d = ST_RAMP_DOWN;
            end
        end
    end

    always_comb begin
`ifdef AUDIO_XFADE_EN
        busy = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
`else
        busy = 1'b0;
`endif
        wet_active = (state_q == ST_WET);
    end

`ifdef AUDIO_XFADE_EN
    localparam int PW = W + RAMP_LOG2 + 2;

    logic signed [PW-1:0] g_wet, g_dry;

    assign g_wet = signed'(PW'(g_d));
    assign g_dry = signed'(PW'(G_MAX - g_d));

    // Convex blend, floor-shifted back to W bits; the endpoints reproduce the inputs exactly.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [PW-1:0] wet_s, dry_s, acc;

        assign wet_s = PW'(signed'(wet_in[c*W +: W]));
        assign dry_s = PW'(signed'(dry_in[c*W +: W]));
        assign acc   = wet_s * g_wet + dry_s * g_dry;
        assign blend[c*W +: W] = W'(acc >>> RAMP_LOG2);
    end
`else
    assign blend = enable ? wet_in : dry_in;
`endif

    always_comb begin
        data_d  = sample_trig ? blend : data_q;
        valid_d = sample_trig;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            g_q     <= '0;
            state_q <= ST_DRY;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            g_q     <= g_d;
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: doc/audio_bypass_xfade.md
# audio_bypass_xfade

Parametrised multi-channel wet/dry selector between the audio codec wrapper and the filter chain, for a click-free filter enable. On every codec sample strobe it outputs the dry (codec) sample, the wet (filtered) sample, or a linear blend of the two. A per-sample gain ramp moves the output between dry and wet over 2^RAMP_LOG2 samples when `enable` toggles. It replaces the plain registered enable mux in the top level and drives the codec's L/R input buses.

## Interface
- `W`, 24, sample width in bits, two's complement.
- `CH`, 2, channel count; channel c occupies bits [c*W +: W], channel 0 at the LSBs.
- `RAMP_LOG2`, 6, log2 of the crossfade length in samples (N = 2^RAMP_LOG2); legal range 1..10.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `enable`  in  1  1 = filtered path requested, 0 = bypass requested; sampled only on `sample_trig`.
- `sample_trig`  in  1  one-cycle strobe per sample period (the codec `ready`).
- `dry_in`  in  CH*W  unfiltered samples, valid when `sample_trig` = 1.
- `wet_in`  in  CH*W  filtered samples, valid when `sample_trig` = 1.
- `data_out`  out  CH*W  blended samples, registered.
- `valid_out`  out  1  one-cycle pulse marking a new `data_out`.
- `busy`  out  1  crossfade in progress (state RAMP_UP or RAMP_DOWN).
- `wet_active`  out  1  state WET (gain = N).

## Operation
- Gain register `g`, range 0..N, shared by all channels; the state is derived from `g` and direction.
- States:
  - DRY: g = 0.
  - RAMP_UP: 0 < g < N, moving up.
  - WET: g = N.
  - RAMP_DOWN: 0 < g < N, moving down.
- On a clock edge with `sample_trig` = 1, `g_next` is computed as follows:
  - `enable` = 1 and g < N: g_next = g + 1.
  - `enable` = 0 and g > 0: g_next = g − 1.
  - Otherwise: g_next = g.
- State after the edge:
  - g_next = N: WET.
  - g_next = 0: DRY.
  - Otherwise: RAMP_UP if `enable` = 1, RAMP_DOWN if `enable` = 0.
- Reversal mid-ramp: the direction flips on the next trig and continues from the current g, with no jump.
- Per channel: out = (wet·g_next + dry·(N − g_next)) >>> RAMP_LOG2.
  - Signed products use W+RAMP_LOG2+2 bits.
  - The shift is an arithmetic right shift (floor rounding).
  - The result is truncated to W bits. No overflow is possible because the blend is a convex combination.
- g_next = 0 gives exactly `dry_in`; g_next = N gives exactly `wet_in`.
- `enable` changes between strobes are ignored until the next `sample_trig`.

## Timing
- Latency: `data_out` and `valid_out` update on the same edge that samples `sample_trig` = 1 (1 clock).
- `valid_out` is high for exactly one cycle; `data_out` holds until the next strobe.
- `busy` and `wet_active` are registered and update on that same edge.
- Back-to-back `sample_trig` on consecutive cycles is legal; each strobe advances g by one.
- Reset (`reset_n` = 0 at a clock edge):
  - g = 0, state DRY.
  - `data_out` = 0, `valid_out` = 0, `busy` = 0, `wet_active` = 0.
  - A `sample_trig` in the same cycle is ignored.
  - Reset during a ramp abandons the ramp; the next strobe after reset starts from g = 0.
- A full ramp takes N strobes (DRY to WET or WET to DRY).

## Configuration
- Macro `AUDIO_XFADE_EN`.
- Defined: gain ramp as described above.
- Undefined:
  - On each strobe, g_next = N if `enable` = 1, else 0.
  - Output is a hard switch between `wet_in` and `dry_in` at the sample boundary.
  - `busy` is tied to 0; no multipliers are instantiated.

## Test plan
- Reset mid-ramp:
  - Stimulus: W=24, RAMP_LOG2=2; trig with enable=1 twice (g=2), assert `reset_n`=0 for one cycle, then trig with enable=0.
  - Required: all outputs 0 during reset; after reset, `data_out` = dry, `busy`=0.
- Ramp up:
  - Stimulus: RAMP_LOG2=2, dry=0x000100, wet=0x000500 on both channels, enable=1, 5 trigs.
  - Required: `data_out` per channel = 0x000200, 0x000300, 0x000400, 0x000500, 0x000500.
  - Required: `busy`=1 after trigs 1–3, `wet_active`=1 after trigs 4 and 5.
- Reversal:
  - Stimulus: same data, enable=1 for 2 trigs, then enable=0.
  - Required: outputs 0x000200, 0x000300, 0x000200, 0x000100; `busy` drops after the 4th trig (DRY).
- Signed floor rounding:
  - Stimulus: RAMP_LOG2=2, dry=0xFFFFFD (−3), wet=0, enable=1, one trig.
  - Required: `data_out` = 0xFFFFFD (−9>>>2 = −3).
- Channel independence:
  - Stimulus: CH=2, ch0 dry=0x7FFFFF/wet=0x800000, ch1 dry=0/wet=0, full ramp.
  - Required: ch1 stays 0; ch0 stays within [0x800000, 0x7FFFFF] and ends at 0x800000.
- Macro undefined:
  - Stimulus: enable 0→1, one trig.
  - Required: `data_out` = wet immediately, `busy` = 0, `wet_active` = 1; enable=0 and one trig gives dry.
